// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver.
// Optional build macro: UART_PKT_RX_CHKSUM_EN adds an XOR checksum byte before ETX.
package uart_pkt_pkg;

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

`ifdef UART_PKT_RX_CHKSUM_EN
    localparam bit CHKSUM_EN = 1'b1;
`else
    localparam bit CHKSUM_EN = 1'b0;
`endif

    // Byte deserialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Total bytes in a packet: STX + header + nb data bytes + [checksum] + ETX
    function automatic int unsigned pkt_len_f(input int unsigned nb, input bit chksum);
        return nb + 32'd3 + (chksum ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: rxd synchroniser, byte FSM and bit timer.
// byte_done / frame_err are single-cycle strobes raised in the stop-sample cycle;
// byte_data holds the last assembled byte and is valid alongside byte_done.
module uart_rx_byte
    import uart_pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 46
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       rx_idle
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);

    logic             sync1_q;
    logic             rs_q;
    logic             rs_prev_q;
    rx_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; reset to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
        end
    end

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    // Next-state logic and sample strobes
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rs_prev_q && !rs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    // Line back high at mid-start means a glitch, not a byte
                    state_d   = rs_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shreg_d   = {rs_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rs_q) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign byte_data = shreg_q;
    assign rx_idle   = (state_q == IDLE);

endmodule

// File: rtl/uart_pkt_rx.sv
// UART STX/ETX command packet receiver with a one-entry command holding register.
// Optional build macro: UART_PKT_RX_CHKSUM_EN (XOR checksum byte before ETX).
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 46,
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              err_frame,
    output logic              err_format,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int NB       = DATA_W / 8;
    localparam int PKT_LEN  = int'(pkt_len_f(NB, CHKSUM_EN));
    localparam int IDX_W    = $clog2(PKT_LEN);
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(NB + 1);
    localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT - 1);

    logic              byte_done;
    logic [7:0]        byte_data;
    logic              frame_err;
    logic              rx_idle;

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              hdr_write_q, hdr_write_d;
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              err_frame_q, err_frame_d;
    logic              err_format_q, err_format_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;
    logic              pkt_ok;
    logic              fmt_ok;
`ifdef UART_PKT_RX_CHKSUM_EN
    localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(NB + 2);
    logic [7:0]        chk_q, chk_d;
    logic              chk_bad_q, chk_bad_d;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .byte_done(byte_done),
        .byte_data(byte_data),
        .frame_err(frame_err),
        .rx_idle  (rx_idle)
    );

    // Packet framing, inter-byte timeout and holding-register next state
    always_comb begin
        byte_idx_d    = byte_idx_q;
        hdr_write_d   = hdr_write_q;
        hdr_addr_d    = hdr_addr_q;
        data_d        = data_q;
        to_cnt_d      = to_cnt_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_data_d    = cmd_data_q;
        err_frame_d   = 1'b0;
        err_format_d  = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        pkt_ok        = 1'b0;
        fmt_ok        = 1'b0;
`ifdef UART_PKT_RX_CHKSUM_EN
        chk_d         = chk_q;
        chk_bad_d     = chk_bad_q;
`endif

        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        // The timeout only measures line silence inside a packet
        if ((byte_idx_q != '0) && rx_idle) begin
            if (to_cnt_q == TO_LAST) begin
                err_timeout_d = 1'b1;
                byte_idx_d    = '0;
                to_cnt_d      = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        if (frame_err) begin
            err_frame_d = 1'b1;
            byte_idx_d  = '0;
        end else if (byte_done) begin
            if (byte_idx_q == '0) begin
                // Anything other than STX is line noise between packets
                if (byte_data == STX) begin
                    byte_idx_d = 1'b1;
                end
            end else if (byte_idx_q == IDX_W'(1)) begin
                hdr_write_d = byte_data[7];
                hdr_addr_d  = byte_data[ADDR_W-1:0];
                byte_idx_d  = byte_idx_q + 1'b1;
`ifdef UART_PKT_RX_CHKSUM_EN
                chk_d       = byte_data;
                chk_bad_d   = 1'b0;
`endif
            end else if (byte_idx_q <= LAST_DATA_IDX) begin
                data_d     = DATA_W'({data_q, byte_data});
                byte_idx_d = byte_idx_q + 1'b1;
`ifdef UART_PKT_RX_CHKSUM_EN
                chk_d      = chk_q ^ byte_data;
`endif
`ifdef UART_PKT_RX_CHKSUM_EN
            end else if (byte_idx_q == CHK_IDX) begin
                chk_bad_d  = (byte_data != chk_q);
                byte_idx_d = byte_idx_q + 1'b1;
`endif
            end else begin
                byte_idx_d = '0;
`ifdef UART_PKT_RX_CHKSUM_EN
                fmt_ok = (byte_data == ETX) && !chk_bad_q;
`else
                fmt_ok = (byte_data == ETX);
`endif
                if (fmt_ok) begin
                    pkt_ok = 1'b1;
                end else begin
                    err_format_d = 1'b1;
                end
            end
        end

        // A handshake in this cycle frees the register for the new packet
        if (pkt_ok) begin
            if (cmd_valid_q && !cmd_ready) begin
                err_overrun_d = 1'b1;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_write_d = hdr_write_q;
                cmd_addr_d  = hdr_addr_q;
                cmd_data_d  = hdr_write_q ? data_q : '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q    <= '0;
            hdr_write_q   <= 1'b0;
            hdr_addr_q    <= '0;
            data_q        <= '0;
            to_cnt_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_data_q    <= '0;
            err_frame_q   <= 1'b0;
            err_format_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_PKT_RX_CHKSUM_EN
            chk_q         <= '0;
            chk_bad_q     <= 1'b0;
`endif
        end else begin
            byte_idx_q    <= byte_idx_d;
            hdr_write_q   <= hdr_write_d;
            hdr_addr_q    <= hdr_addr_d;
            data_q        <= data_d;
            to_cnt_q      <= to_cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_data_q    <= cmd_data_d;
            err_frame_q   <= err_frame_d;
            err_format_q  <= err_format_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
`ifdef UART_PKT_RX_CHKSUM_EN
            chk_q         <= chk_d;
            chk_bad_q     <= chk_bad_d;
`endif
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_write   = cmd_write_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_data    = cmd_data_q;
    assign err_frame   = err_frame_q;
    assign err_format  = err_format_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Scoreboard bench for uart_pkt_rx: stimulus pushes expected events, a monitor pops and compares.
module tb_uart_pkt_rx;

    localparam int CPB     = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 2000;

    localparam int EV_CMD     = 0;
    localparam int EV_FRAME   = 1;
    localparam int EV_FORMAT  = 2;
    localparam int EV_TIMEOUT = 3;
    localparam int EV_OVERRUN = 4;

    typedef struct {
        int                kind;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rxd = 1'b1;
    logic              cmd_ready = 1'b1;
    logic              cmd_valid;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              err_frame;
    logic              err_format;
    logic              err_timeout;
    logic              err_overrun;

    always #5 clk = ~clk;

    uart_pkt_rx #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .err_frame  (err_frame),
        .err_format (err_format),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none t=%0t", kind, $time);
            return;
        end
        e = exp_q.pop_front();
        check_val("event_kind", 64'(kind), 64'(e.kind));
        if (kind == EV_CMD && e.kind == EV_CMD) begin
            check_val("cmd_write", 64'(cmd_write), 64'(e.wr));
            check_val("cmd_addr", 64'(cmd_addr), 64'(e.addr));
            check_val("cmd_data", 64'(cmd_data), 64'(e.data));
        end
        $display("event kind=%0d wr=%0d addr=0x%0h data=0x%0h t=%0t",
                 kind, cmd_write, cmd_addr, cmd_data, $time);
    endtask

    // Monitor: sample outputs on the falling edge and match against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (cmd_valid && cmd_ready) check_event(EV_CMD);
            if (err_frame)   check_event(EV_FRAME);
            if (err_format)  check_event(EV_FORMAT);
            if (err_timeout) check_event(EV_TIMEOUT);
            if (err_overrun) check_event(EV_OVERRUN);
        end
    end

    task automatic push_ev(input int kind);
        exp_t e;
        e.kind = kind;
        e.wr   = 1'b0;
        e.addr = '0;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        exp_t e;
        e.kind = EV_CMD;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rxd = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_pkt(input logic [55:0] p);
        for (int i = 0; i < 7; i++) begin
            send_byte(p[55 - 8*i -: 8], 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #900us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Line activity during reset must be ignored
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) rxd = ~rxd;
        end
        rxd = 1'b1;
        idle(3);
        check_val("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check_val("rst_cmd_data", 64'(cmd_data), 64'd0);
        check_val("rst_cmd_addr_write", 64'({cmd_write, cmd_addr}), 64'd0);
        check_val("rst_errors", 64'({err_frame, err_format, err_timeout, err_overrun}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        idle(20);

        // Write packet
        push_cmd(1'b1, 7'h05, 32'hDEADBEEF);
        send_pkt(56'h02_85_DE_AD_BE_EF_03);
        idle(20);

        // Read packets: data is ignored, cmd_data must be zero
        push_cmd(1'b0, 7'h12, 32'h0);
        send_pkt(56'h02_12_00_00_00_00_03);
        idle(5);
        push_cmd(1'b0, 7'h33, 32'h0);
        send_pkt(56'h02_33_AA_BB_CC_DD_03);
        idle(20);

        // Bad ETX, then a good packet at the top address
        push_ev(EV_FORMAT);
        send_pkt(56'h02_85_DE_AD_BE_EF_04);
        idle(20);
        push_cmd(1'b1, 7'h7F, 32'h01020304);
        send_pkt(56'h02_FF_01_02_03_04_03);
        idle(20);

        // Overrun: consumer stalled across two packets
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        push_ev(EV_OVERRUN);
        push_cmd(1'b1, 7'h05, 32'h11223344);
        send_pkt(56'h02_85_11_22_33_44_03);
        idle(5);
        send_pkt(56'h02_86_55_66_77_88_03);
        idle(10);
        check_val("held_valid", 64'(cmd_valid), 64'd1);
        check_val("held_addr", 64'(cmd_addr), 64'h05);
        check_val("held_data", 64'(cmd_data), 64'h11223344);
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        idle(20);

        // Timeout after STX + header, then recovery
        push_ev(EV_TIMEOUT);
        send_byte(8'h02, 1'b1);
        send_byte(8'h85, 1'b1);
        idle(TIMEOUT + 500);
        push_cmd(1'b1, 7'h21, 32'hCAFEF00D);
        send_pkt(56'h02_A1_CA_FE_F0_0D_03);
        idle(20);

        // 6-cycle glitch: no byte, no error
        @(negedge clk) rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        idle(200);
        check_val("glitch_no_event", 64'(exp_q.size()), 64'd0);

        // Stop bit low aborts the packet; a fresh packet then succeeds
        push_ev(EV_FRAME);
        send_byte(8'h02, 1'b1);
        send_byte(8'h85, 1'b1);
        send_byte(8'hAA, 1'b0);
        idle(20);
        push_cmd(1'b1, 7'h0A, 32'h00000001);
        send_pkt(56'h02_8A_00_00_00_01_03);

        // Drain with a bounded wait
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        idle(50);
        check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
